// File: rtl/pdm_m_pkg.sv
// pdm_m_pkg: shared types and constants for the PDM capture buffer.
//   state_e      : capture FSM states (IDLE, ARMED, CAPTURE)
//   CMD_*        : encodings of the 2-bit ctrl command input
//   DEF_*        : default buffer base address and depth
package pdm_m_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [1:0] CMD_CLEAR = 2'b10;
  localparam logic [1:0] CMD_ABORT = 2'b11;

  localparam logic [31:0] DEF_BASE_ADDR   = 32'h4000_0000;
  localparam int          DEF_DEPTH_WORDS = 1024;

endpackage

// File: rtl/pdm_m_sync_edge.sv
// pdm_m_sync_edge: brings the PDM bit clock and data bit into the system
// clock domain and flags each rising edge of the bit clock.
//   clk        in  system clock
//   rst        in  synchronous active-high reset (edge-detect control only)
//   pdm_clk    in  asynchronous PDM bit clock, treated as data
//   pdm_data   in  asynchronous PDM data bit
//   sample_en  out one-cycle pulse on a rising edge of the synchronized bit clock
//   sample_bit out data bit taken from the same synchronizer depth as the clock
module pdm_m_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pdm_clk,
  input  logic pdm_data,
  output logic sample_en,
  output logic sample_bit
);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;

  // Both chains have equal depth so the data bit stays aligned with its clock edge.
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], pdm_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], pdm_data};
    clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q <= '0;
      clk_prev_q <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      clk_prev_q <= clk_prev_d;
    end
  end

  always_ff @(posedge clk) begin
    data_sync_q <= data_sync_d;
  end

  assign sample_en  = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
  assign sample_bit = data_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pdm_m.sv
// pdm_m: captures a 1-bit PDM microphone stream into an on-chip word buffer
// that a bus master reads back by byte address.
//   AHBclk     in  sole clock
//   rst        in  synchronous active-high reset
//   PDMclk     in  PDM bit clock (synchronized, sampled as data)
//   ctrl       in  command: 00 none, 01 START, 10 CLEAR, 11 ABORT
//   addr       in  byte read address
//   pdm_signal in  PDM data bit
//   dout       out registered read data (one cycle after addr)
//   bsy        out capture armed or in progress
// Build option PDM_M_STATUS_EN: the address one word past the buffer returns
// {bsy, done, state, 12'b0, word_ptr[10:0], bit_cnt[4:0]}; otherwise it reads 0.
module pdm_m
  import pdm_m_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        AHBclk,
  input  logic        rst,
  input  logic        PDMclk,
  input  logic [1:0]  ctrl,
  input  logic [31:0] addr,
  input  logic        pdm_signal,
  output logic [31:0] dout,
  output logic        bsy
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam int          PTR_W = IDX_W + 1;
  localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS * 4);

  logic sample_en, sample_bit;

  pdm_m_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (AHBclk),
    .rst        (rst),
    .pdm_clk    (PDMclk),
    .pdm_data   (pdm_signal),
    .sample_en  (sample_en),
    .sample_bit (sample_bit)
  );

  state_e             state_q, state_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic [PTR_W-1:0]   word_ptr_q, word_ptr_d;
  logic               done_q, done_d;
  logic [31:0]        sr_q, sr_d;

  logic               we;
  logic [31:0]        wdata;
  logic [IDX_W-1:0]   widx;

  logic [31:0]        mem [DEPTH_WORDS];

  assign bsy = (state_q != IDLE);

  // Capture FSM. CLEAR/ABORT take priority over any sample event in the same cycle.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_ptr_d = word_ptr_q;
    done_d     = done_q;
    sr_d       = sr_q;
    we         = 1'b0;
    wdata      = {sr_q[30:0], sample_bit};
    widx       = word_ptr_q[IDX_W-1:0];

    if (ctrl == CMD_CLEAR) begin
      state_d    = IDLE;
      bit_cnt_d  = '0;
      word_ptr_d = '0;
      done_d     = 1'b0;
    end else if (ctrl == CMD_ABORT) begin
      state_d = IDLE;
    end else if (ctrl == CMD_START && state_q == IDLE) begin
      state_d    = ARMED;
      bit_cnt_d  = '0;
      word_ptr_d = '0;
      done_d     = 1'b0;
    end else if (sample_en && state_q != IDLE) begin
      state_d   = CAPTURE;
      sr_d      = wdata;
      bit_cnt_d = bit_cnt_q + 5'd1;
      if (bit_cnt_q == 5'd31) begin
        we         = 1'b1;
        word_ptr_d = word_ptr_q + PTR_W'(1);
        if (word_ptr_q == PTR_W'(DEPTH_WORDS - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge AHBclk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      word_ptr_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_ptr_q <= word_ptr_d;
      done_q     <= done_d;
    end
  end

  // A restarted capture overwrites the shift register entirely before the
  // next write, so stale contents never reach memory.
  always_ff @(posedge AHBclk) begin
    sr_q <= sr_d;
  end

  // Read decode. The subtraction wraps, so addresses below BASE_ADDR land far out of range.
  logic [31:0]      rd_off;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_hit_d, rd_hit_q;
  logic [31:0]      misc_d, misc_q;
  logic [31:0]      mem_rd_q;

  always_comb begin
    rd_off   = addr - BASE_ADDR;
    rd_hit_d = (rd_off < SPAN);
    rd_idx   = rd_off[IDX_W+1:2];
    misc_d   = '0;
`ifdef PDM_M_STATUS_EN
    if (rd_off == SPAN) begin
      misc_d = {bsy, done_q, state_q, 12'b0, 11'(word_ptr_q), bit_cnt_q};
    end
`endif
  end

  // Simple dual-port RAM: read-before-write, so a same-word collision returns old data.
  always_ff @(posedge AHBclk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
    mem_rd_q <= mem[rd_idx];
  end

  always_ff @(posedge AHBclk) begin
    if (rst) begin
      rd_hit_q <= 1'b0;
      misc_q   <= '0;
    end else begin
      rd_hit_q <= rd_hit_d;
      misc_q   <= misc_d;
    end
  end

  assign dout = rd_hit_q ? mem_rd_q : misc_q;

endmodule

// File: tb/tb_pdm_m.sv
module tb_pdm_m;
  import pdm_m_pkg::*;

  logic        AHBclk = 1'b0;
  logic        rst;
  logic        PDMclk;
  logic [1:0]  ctrl;
  logic [31:0] addr;
  logic        pdm_signal;
  logic [31:0] dout;
  logic        bsy;

  int n_cmp = 0;
  int n_mis = 0;

  localparam logic [31:0] BASE = 32'h4000_0000;

  pdm_m dut (
    .AHBclk     (AHBclk),
    .rst        (rst),
    .PDMclk     (PDMclk),
    .ctrl       (ctrl),
    .addr       (addr),
    .pdm_signal (pdm_signal),
    .dout       (dout),
    .bsy        (bsy)
  );

  always #5 AHBclk = ~AHBclk;

  function automatic logic [31:0] word_val(input int w);
    if (w < 2) return 32'hA5A5_0F0F;
    return (32'(w) * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge AHBclk);
    pdm_signal = b;
    PDMclk     = 1'b0;
    @(negedge AHBclk);
    PDMclk     = 1'b1;
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 31; i > 31 - n; i--) send_bit(w[i]);
  endtask

  task automatic cmd(input logic [1:0] c);
    @(negedge AHBclk);
    ctrl = c;
    @(negedge AHBclk);
    ctrl = CMD_NONE;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    @(negedge AHBclk);
    addr = a;
    @(negedge AHBclk);
    chk(tag, dout, exp);
  endtask

  task automatic settle();
    repeat (6) @(negedge AHBclk);
  endtask

  initial begin
    logic [31:0] status_exp;
    int          t;

    // 1: reset
    rst = 1'b1; ctrl = CMD_NONE; addr = BASE; PDMclk = 1'b0; pdm_signal = 1'b0;
    repeat (3) @(negedge AHBclk);
    chk("rst_bsy", {31'b0, bsy}, 32'd0);
    chk("rst_dout", dout, 32'd0);
    rst = 1'b0;
    chk("rst_release_dout", dout, 32'd0);

    // 2/3: full capture, first two words carry the A5A50F0F pattern
    cmd(CMD_CLEAR);
    cmd(CMD_START);
    chk("bsy_after_start", {31'b0, bsy}, 32'd1);
    for (int w = 0; w < 1024; w++) begin
      chk($sformatf("bsy_capture_w%0d", w), {31'b0, bsy}, 32'd1);
      send_bits(word_val(w), 32);
    end
    t = 0;
    while (bsy && t < 20) begin
      @(negedge AHBclk);
      t++;
    end
    chk("bsy_after_last", {31'b0, bsy}, 32'd0);
    settle();
    for (int w = 0; w < 1024; w++)
      rd(BASE + 32'(4 * w), word_val(w), $sformatf("mem_w%0d", w));
    rd(32'h4000_0007, 32'hA5A5_0F0F, "low_bits_ignored");

    // 5: range and status
    rd(32'h4000_1004, 32'd0, "range_hi");
    rd(32'h3FFF_FFFC, 32'd0, "range_lo");
`ifdef PDM_M_STATUS_EN
    status_exp = 32'h4000_0000 | (32'd1024 << 5);
`else
    status_exp = 32'd0;
`endif
    rd(32'h4000_1000, status_exp, "status_addr");

    // 4: START during capture ignored, ctrl=00 keeps capturing, ABORT stops
    cmd(CMD_START);
    send_bits(32'hDEAD_BEEF, 32);
    send_bits(32'h1234_5678, 8);
    settle();
    cmd(CMD_START);
    chk("start_in_capture_bsy", {31'b0, bsy}, 32'd1);
    send_bits(32'h0034_5678 << 8, 24);
    settle();
    cmd(CMD_ABORT);
    chk("abort_bsy", {31'b0, bsy}, 32'd0);
    send_bits(32'h0000_0000, 32);
    settle();
    rd(BASE + 32'd0, 32'hDEAD_BEEF, "cmd_w0");
    rd(BASE + 32'd4, 32'h1234_5678, "cmd_w1");
    rd(BASE + 32'd8, word_val(2), "abort_w2_kept");

    // 6: reset mid-capture, then a fresh capture from word 0
    cmd(CMD_START);
    send_bits(32'hCAFE_F00D, 32);
    send_bits(32'hFFFF_FFFF, 16);
    @(negedge AHBclk);
    rst = 1'b1;
    @(negedge AHBclk);
    rst = 1'b0;
    chk("rst_mid_bsy", {31'b0, bsy}, 32'd0);
    settle();
    cmd(CMD_START);
    chk("restart_bsy", {31'b0, bsy}, 32'd1);
    send_bits(32'h0BAD_C0DE, 32);
    settle();
    rd(BASE + 32'd0, 32'h0BAD_C0DE, "restart_w0");
    rd(BASE + 32'd4, 32'h1234_5678, "partial_discarded_w1");
    cmd(CMD_ABORT);
    chk("final_abort_bsy", {31'b0, bsy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
